// File: rtl/mem_wait_bridge_if.sv
// Processor12 memory port plus SRAM port, bundled for the mem_wait_bridge.
// slave = bridge view, master = processor/SRAM environment view.
interface mem_wait_bridge_if #(
    parameter int ADDR_BITS = 12
);
    logic [23:0]          cpu_address;
    logic                 cpu_read;
    logic                 cpu_write;
    logic [11:0]          cpu_wdata;
    logic [11:0]          cpu_rdata;
    logic                 cpu_ready;
    logic [ADDR_BITS-1:0] ram_addr;
    logic                 ram_re;
    logic                 ram_we;
    logic [11:0]          ram_wdata;
    logic [11:0]          ram_rdata;
    logic                 bus_fault;

    modport slave (
        input  cpu_address, cpu_read, cpu_write, cpu_wdata, ram_rdata,
        output cpu_rdata, cpu_ready, ram_addr, ram_re, ram_we, ram_wdata, bus_fault
    );

    modport master (
        output cpu_address, cpu_read, cpu_write, cpu_wdata, ram_rdata,
        input  cpu_rdata, cpu_ready, ram_addr, ram_re, ram_we, ram_wdata, bus_fault
    );
endinterface

// File: rtl/mem_wait_bridge.sv
// Processor12 -> single-port SRAM bridge: ready handshake, wait states, address window decode.
// Optional one-entry posted write buffer: define MEM_WAIT_BRIDGE_WRITE_BUFFER_EN.
module mem_wait_bridge #(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_wait_bridge_if.slave  bus
);
`ifdef MEM_WAIT_BRIDGE_WRITE_BUFFER_EN
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT} state_t;
`endif

    localparam logic [3:0] W_LD    = 4'(WAIT_STATES);
    localparam logic [3:0] W_LD_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rd_q, rd_d;
    logic       fault_q, fault_d;
`ifdef MEM_WAIT_BRIDGE_WRITE_BUFFER_EN
    logic [ADDR_BITS-1:0] buf_addr_q, buf_addr_d;
    logic [11:0]          buf_data_q, buf_data_d;
    logic                 buf_pend_q, buf_pend_d;
`endif

    logic                 ready, re, we;
    logic [11:0]          rdata, wdata;
    logic [ADDR_BITS-1:0] addr;
    logic                 req, oor;

    assign req = bus.cpu_read | bus.cpu_write;
    assign oor = (bus.cpu_address >> ADDR_BITS) != 24'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        fault_d = fault_q;
        ready   = 1'b0;
        rdata   = 12'o0000;
        re      = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = 12'o0000;
`ifdef MEM_WAIT_BRIDGE_WRITE_BUFFER_EN
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_pend_d = buf_pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (!req) begin
                    ready = 1'b1;
                end else if (oor) begin
                    ready   = 1'b1;
                    fault_d = 1'b1;
                end else begin
                    // read+write together is a protocol error; the write wins
                    if (bus.cpu_read && bus.cpu_write) fault_d = 1'b1;
                    if (bus.cpu_write) begin
                        rd_d = 1'b0;
`ifdef MEM_WAIT_BRIDGE_WRITE_BUFFER_EN
                        ready      = 1'b1;
                        buf_addr_d = bus.cpu_address[ADDR_BITS-1:0];
                        buf_data_d = bus.cpu_wdata;
                        buf_pend_d = 1'b1;
                        state_d    = DRAIN;
`else
                        we    = 1'b1;
                        addr  = bus.cpu_address[ADDR_BITS-1:0];
                        wdata = bus.cpu_wdata;
                        if (WAIT_STATES == 0) begin
                            ready = 1'b1;
                        end else begin
                            cnt_d   = W_LD_M1;
                            state_d = WAIT;
                        end
`endif
                    end else begin
                        re      = 1'b1;
                        addr    = bus.cpu_address[ADDR_BITS-1:0];
                        rd_d    = 1'b1;
                        cnt_d   = W_LD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    ready   = 1'b1;
                    rdata   = rd_q ? bus.ram_rdata : 12'o0000;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef MEM_WAIT_BRIDGE_WRITE_BUFFER_EN
            DRAIN: begin
                // bus traffic that never touches the SRAM is not held off by the drain
                if (!req) begin
                    ready = 1'b1;
                end else if (oor) begin
                    ready   = 1'b1;
                    fault_d = 1'b1;
                end
                if (buf_pend_q) begin
                    we         = 1'b1;
                    addr       = buf_addr_q;
                    wdata      = buf_data_q;
                    buf_pend_d = 1'b0;
                    cnt_d      = W_LD_M1;
                    if (WAIT_STATES == 0) state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            fault_q <= 1'b0;
`ifdef MEM_WAIT_BRIDGE_WRITE_BUFFER_EN
            buf_addr_q <= '0;
            buf_data_q <= 12'o0000;
            buf_pend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            fault_q <= fault_d;
`ifdef MEM_WAIT_BRIDGE_WRITE_BUFFER_EN
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            buf_pend_q <= buf_pend_d;
`endif
        end
    end

    // while reset is held the decode logic still sees live requests; mask it
    assign bus.cpu_ready = rst ? ready : 1'b1;
    assign bus.cpu_rdata = rst ? rdata : 12'o0000;
    assign bus.ram_re    = rst & re;
    assign bus.ram_we    = rst & we;
    assign bus.ram_addr  = rst ? addr : '0;
    assign bus.ram_wdata = rst ? wdata : 12'o0000;
    assign bus.bus_fault = fault_q;
endmodule

// File: tb/tb_mem_wait_bridge.sv
// Bench for mem_wait_bridge: three instances (W=0,2,3) each with an SRAM model,
// table-driven transactions checked through a scoreboard plus reset/buffer sequences.
module tb_mem_wait_bridge;
    typedef struct {
        int          sel;
        logic [23:0] addr;
        logic        rd;
        logic        wr;
        logic [11:0] wdata;
        int          lat;
        logic [11:0] rdata;
        logic        fault;
    } vec_t;

`ifdef MEM_WAIT_BRIDGE_WRITE_BUFFER_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] t_addr [3];
    logic        t_rd [3];
    logic        t_wr [3];
    logic [11:0] t_wdata [3];
    logic [2:0]  rdy, re, we, flt;
    logic [11:0] rdat [3];
    logic [11:0] raddr [3];
    int          re_cnt [3] = '{0, 0, 0};
    int          we_cnt [3] = '{0, 0, 0};
    int          both_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    vec_t        sb [$];
    vec_t        tbl [14];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int W = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        mem_wait_bridge_if #(.ADDR_BITS(12)) bus ();
        logic [11:0] mem [4096];
        logic [11:0] pipe [16];

        mem_wait_bridge #(.ADDR_BITS(12), .WAIT_STATES(W)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        assign bus.cpu_address = t_addr[g];
        assign bus.cpu_read    = t_rd[g];
        assign bus.cpu_write   = t_wr[g];
        assign bus.cpu_wdata   = t_wdata[g];
        assign rdy[g]   = bus.cpu_ready;
        assign re[g]    = bus.ram_re;
        assign we[g]    = bus.ram_we;
        assign flt[g]   = bus.bus_fault;
        assign rdat[g]  = bus.cpu_rdata;
        assign raddr[g] = bus.ram_addr;
        // read data is only meaningful exactly W+1 cycles after the strobe
        assign bus.ram_rdata = pipe[W];

        initial begin
            for (int i = 0; i < 4096; i++) mem[i] = (i == 5) ? 12'o1234 : 12'(i * 7 + 1);
            for (int i = 0; i < 16; i++) pipe[i] = 12'o7777;
        end

        always @(posedge clk) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            pipe[0] <= bus.ram_re ? mem[bus.ram_addr] : 12'o7777;
            for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
        end
    end

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (re[g]) re_cnt[g] <= re_cnt[g] + 1;
            if (we[g]) we_cnt[g] <= we_cnt[g] + 1;
            if (re[g] && we[g]) both_cnt <= both_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic xact(input vec_t v);
        vec_t        e;
        int          lat, re0, we0, s;
        logic [11:0] got;
        logic        inr;
        s   = v.sel;
        re0 = re_cnt[s];
        we0 = we_cnt[s];
        inr = (v.addr >> 12) == 24'd0;
        sb.push_back(v);
        t_addr[s] = v.addr; t_rd[s] = v.rd; t_wr[s] = v.wr; t_wdata[s] = v.wdata;
        lat = 0;
        @(negedge clk);
        while (!rdy[s] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got = rdat[s];
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("cpu_rdata", int'(got), int'(e.rdata));
        @(posedge clk); #1;
        t_rd[s] = 1'b0; t_wr[s] = 1'b0; t_addr[s] = 24'd0; t_wdata[s] = 12'd0;
        repeat (5) @(negedge clk);
        chk("ram_re pulses", re_cnt[s] - re0, int'(e.rd && !e.wr && inr));
        chk("ram_we pulses", we_cnt[s] - we0, int'(e.wr && inr));
        chk("bus_fault", int'(flt[s]), int'(e.fault));
        @(posedge clk); #1;
    endtask

    initial begin
        int re0, we0, lat;
        tbl[0]  = '{1, 24'o00000005, 1'b1, 1'b0, 12'o0000, 3,            12'o1234, 1'b0};
        tbl[1]  = '{0, 24'o00000010, 1'b0, 1'b1, 12'o7070, 0,            12'o0000, 1'b0};
        tbl[2]  = '{0, 24'o00000010, 1'b1, 1'b0, 12'o0000, 1,            12'o7070, 1'b0};
        tbl[3]  = '{2, 24'o00000077, 1'b0, 1'b1, 12'o1111, BUF ? 0 : 3,  12'o0000, 1'b0};
        tbl[4]  = '{2, 24'o00000077, 1'b1, 1'b0, 12'o0000, 4,            12'o1111, 1'b0};
        tbl[5]  = '{1, 24'o00007777, 1'b0, 1'b1, 12'o4321, BUF ? 0 : 2,  12'o0000, 1'b0};
        tbl[6]  = '{1, 24'o00007777, 1'b1, 1'b0, 12'o0000, 3,            12'o4321, 1'b0};
        tbl[7]  = '{1, 24'o00010000, 1'b1, 1'b0, 12'o0000, 0,            12'o0000, 1'b1};
        tbl[8]  = '{1, 24'o00000005, 1'b1, 1'b0, 12'o0000, 3,            12'o1234, 1'b1};
        tbl[9]  = '{0, 24'o00010000, 1'b0, 1'b1, 12'o6666, 0,            12'o0000, 1'b1};
        tbl[10] = '{0, 24'o00000000, 1'b1, 1'b0, 12'o0000, 1,            12'o0001, 1'b1};
        tbl[11] = '{2, 24'o00000020, 1'b1, 1'b1, 12'o2525, BUF ? 0 : 3,  12'o0000, 1'b1};
        tbl[12] = '{2, 24'o00000020, 1'b1, 1'b0, 12'o0000, 4,            12'o2525, 1'b1};
        tbl[13] = '{0, 24'o00000000, 1'b0, 1'b0, 12'o0000, 0,            12'o0000, 1'b1};

        for (int g = 0; g < 3; g++) begin
            t_addr[g] = 24'd0; t_rd[g] = 1'b0; t_wr[g] = 1'b0; t_wdata[g] = 12'd0;
        end
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("reset cpu_ready", int'(rdy[g]), 1);
            chk("reset cpu_rdata", int'(rdat[g]), 0);
            chk("reset ram_re", int'(re[g]), 0);
            chk("reset ram_we", int'(we[g]), 0);
            chk("reset ram_addr", int'(raddr[g]), 0);
            chk("reset bus_fault", int'(flt[g]), 0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) xact(tbl[i]);

        // reset in the middle of a W=3 read
        re0 = re_cnt[2];
        t_addr[2] = 24'o00000005; t_rd[2] = 1'b1;
        @(negedge clk);
        chk("rd0 ram_re", int'(re[2]), 1);
        chk("rd0 cpu_ready", int'(rdy[2]), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; t_rd[2] = 1'b0; t_addr[2] = 24'd0;
        #1;
        chk("mid-reset cpu_ready", int'(rdy[2]), 1);
        chk("mid-reset ram_re", int'(re[2]), 0);
        chk("mid-reset ram_we", int'(we[2]), 0);
        chk("mid-reset bus_fault", int'(flt[1]), 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("post-reset no strobe", re_cnt[2] - re0, 1);
        @(posedge clk); #1;
        xact('{2, 24'o00000005, 1'b1, 1'b0, 12'o0000, 4, 12'o1234, 1'b0});

`ifdef MEM_WAIT_BRIDGE_WRITE_BUFFER_EN
        // posted write, then an immediate read of the same word (W=2)
        we0 = we_cnt[1];
        t_addr[1] = 24'o00000100; t_wr[1] = 1'b1; t_wdata[1] = 12'o3456;
        @(negedge clk);
        chk("buf wr ready", int'(rdy[1]), 1);
        chk("buf wr no strobe c0", int'(we[1]), 0);
        @(posedge clk); #1;
        t_wr[1] = 1'b0; t_rd[1] = 1'b1;
        @(negedge clk);
        chk("buf ram_we c1", int'(we[1]), 1);
        chk("buf ram_addr c1", int'(raddr[1]), 24'o100);
        chk("buf rd stalls", int'(rdy[1]), 0);
        lat = 0;
        while (!rdy[1] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("buf rd latency", lat, 6);
        chk("buf rd data", int'(rdat[1]), int'(12'o3456));
        chk("buf we pulses", we_cnt[1] - we0, 1);
        @(posedge clk); #1;
        t_rd[1] = 1'b0; t_addr[1] = 24'd0;
        repeat (4) @(posedge clk); #1;
`else
        we0 = 0;
        lat = 0;
`endif

        chk("strobes never together", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
